handshake_tx: RTL

Clocked producer stage that feeds the muller_C handshake pipeline. Accepts words from a synchronous valid/ready source into a small FIFO, then issues each word as a 4-phase (return-to-zero) bundled-data transfer on `request`/`out_data`, completing on the asynchronous `ack` returned by the C-element stage. The `ack` input is synchronized internally. The block is the sole driver of the pipeline's first `request`.

---
 rtl/handshake_pkg.sv | 18 +
 rtl/handshake_sync.sv | 29 ++
 rtl/handshake_tx.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/handshake_pkg.sv
// handshake_pkg: types and defaults shared by the handshake pipeline blocks.
// Holds the 4-phase producer FSM state encoding and the default depth of
// the acknowledge synchronizer.

package handshake_pkg;

  // 4-phase producer states: wait for data, hold data before request,
  // request high awaiting ack, request low awaiting ack release
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    REQ_HI = 2'd2,
    REQ_LO = 2'd3
  } hs_state_t;

  localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/handshake_sync.sv
// handshake_sync: plain flop-chain synchronizer for a single asynchronous bit.
// The chain clears to 0 under the asynchronous active-low reset.

module handshake_sync
  import handshake_pkg::*;
#(
  parameter int STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through STAGES flops; the last flop is the
  // only one the rest of the design may look at
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/handshake_tx.sv
// handshake_tx: clocked producer feeding the 4-phase bundled-data pipeline.
// Words arrive on a valid/ready port into a small FIFO and leave one at a
// time on request/out_data, completing on the synchronized ack.
// Optional feature: define HANDSHAKE_TX_TIMEOUT_EN to abort a handshake
// phase that lasts TIMEOUT cycles and raise the sticky err flag.

module handshake_tx
  import handshake_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int SETUP_CYC   = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              request,
  input  logic              ack,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              err
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int SETUP_W = $clog2(SETUP_CYC + 1);

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;

  hs_state_t          state;
  hs_state_t          state_nxt;
  logic [SETUP_W-1:0] setup_cnt;
  logic [SETUP_W-1:0] setup_cnt_nxt;
  logic               request_nxt;
  logic               ack_s;
  logic               timeout_hit;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign in_ready   = !fifo_full;
  assign push       = in_valid && in_ready;
  assign busy       = (state != IDLE) || !fifo_empty;

  handshake_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ack),
    .q     (ack_s)
  );

  // FIFO storage needs no reset; occupancy is tracked by count alone
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; a same-edge push and pop leave count alone
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The bundled data register only loads when a word leaves the FIFO, which
  // is always the SETUP entry edge, so it is stable for the whole handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data <= '0;
    end else if (pop) begin
      out_data <= mem[rd_ptr];
    end
  end

`ifdef HANDSHAKE_TX_TIMEOUT_EN
  localparam int PHASE_W = $clog2(TIMEOUT + 1);

  logic [PHASE_W-1:0] phase_cnt;
  logic               err_q;

  // Abort a phase whose ack transition has not arrived after TIMEOUT cycles
  assign timeout_hit = (phase_cnt == PHASE_W'(TIMEOUT - 1)) &&
                       (((state == REQ_HI) && !ack_s) ||
                        ((state == REQ_LO) &&  ack_s));

  // Count cycles spent in the current REQ_HI/REQ_LO phase, restarting on entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_cnt <= '0;
    end else if ((state_nxt != state) ||
                 ((state != REQ_HI) && (state != REQ_LO))) begin
      phase_cnt <= '0;
    end else begin
      phase_cnt <= phase_cnt + 1'b1;
    end
  end

  // Sticky error flag, only cleared by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign err            = 1'b0;
  // TIMEOUT only matters when the abort logic is built in
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // FSM state, setup counter and the registered request line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      setup_cnt <= '0;
      request   <= 1'b0;
    end else begin
      state     <= state_nxt;
      setup_cnt <= setup_cnt_nxt;
      request   <= request_nxt;
    end
  end

  // Next-state logic: a word is popped on SETUP entry, request rises after
  // SETUP_CYC cycles and falls on ack, and the return-to-zero phase either
  // chains straight into the next word or drops back to IDLE
  always_comb begin
    state_nxt     = state;
    setup_cnt_nxt = setup_cnt;
    request_nxt   = request;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_nxt     = SETUP;
          setup_cnt_nxt = '0;
          pop           = 1'b1;
        end
      end
      SETUP: begin
        if (setup_cnt == SETUP_W'(SETUP_CYC - 1)) begin
          state_nxt   = REQ_HI;
          request_nxt = 1'b1;
        end else begin
          setup_cnt_nxt = setup_cnt + 1'b1;
        end
      end
      REQ_HI: begin
        if (ack_s) begin
          state_nxt   = REQ_LO;
          request_nxt = 1'b0;
        end else if (timeout_hit) begin
          state_nxt   = IDLE;
          request_nxt = 1'b0;
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          if (!fifo_empty) begin
            state_nxt     = SETUP;
            setup_cnt_nxt = '0;
            pop           = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (timeout_hit) begin
          state_nxt   = IDLE;
          request_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt   = IDLE;
        request_nxt = 1'b0;
      end
    endcase
  end

endmodule
